// File: rtl/csa_tree_pipe_pkg.sv
// Shared helpers for the pipelined carry-save reduction tree: level/stage
// counting and the per-level vector count of the 4:2 / 3:2 schedule.
package csa_tree_pipe_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return r;
    endfunction

    function automatic int csa_levels(input int n);
        return (clog2(n) > 1) ? clog2(n) - 1 : 0;
    endfunction

    function automatic int csa_stages(input int levels, input int reg_every);
        int s;
        s = (levels + reg_every - 1) / reg_every;
        return (s < 1) ? 1 : s;
    endfunction

    // Groups of four become two vectors; a leftover three is compressed to two,
    // a leftover two or one passes straight through.
    function automatic int csa_next_count(input int n);
        return 2 * (n / 4) + (((n % 4) == 3) ? 2 : (n % 4));
    endfunction

    function automatic int csa_count(input int n, input int k);
        int c;
        c = n;
        for (int i = 0; i < k; i++) begin
            c = csa_next_count(c);
        end
        return c;
    endfunction

endpackage

// File: rtl/csa_tree_pipe_if.sv
// Operand-in / redundant-sum-out bundle of the reduction tree.
// valid/ready: a beat moves on either side exactly when valid and ready are both high.
interface csa_tree_pipe_if import csa_tree_pipe_pkg::*; #(
    parameter int N         = 8,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = IN_WIDTH + clog2(N),
    parameter int TAG_WIDTH = 4
);
    logic                          valid_i;
    logic                          ready_o;
    logic [N-1:0][IN_WIDTH-1:0]    operands_i;
    logic                          signed_i;
    logic [TAG_WIDTH-1:0]          tag_i;
    logic                          valid_o;
    logic                          ready_i;
    logic [OUT_WIDTH-1:0]          sum_o;
    logic [OUT_WIDTH-1:0]          carry_o;
    logic [OUT_WIDTH-1:0]          result_o;
    logic [TAG_WIDTH-1:0]          tag_o;

    modport slave (
        input  valid_i, operands_i, signed_i, tag_i, ready_i,
        output ready_o, valid_o, sum_o, carry_o, result_o, tag_o
    );

    modport master (
        output valid_i, operands_i, signed_i, tag_i, ready_i,
        input  ready_o, valid_o, sum_o, carry_o, result_o, tag_o
    );
endinterface

// File: rtl/csa_tree_pipe_reduce_level.sv
// One combinational reduction level: N_IN vectors in, csa_next_count(N_IN) out.
// A 4:2 compressor is built as two chained 3:2 compressors.
module csa_tree_pipe_reduce_level import csa_tree_pipe_pkg::*; #(
    parameter int N_IN  = 8,
    parameter int WIDTH = 11,
    localparam int N_OUT = csa_next_count(N_IN)
) (
    input  logic [N_IN-1:0][WIDTH-1:0]  in_vec,
    output logic [N_OUT-1:0][WIDTH-1:0] out_vec
);
    localparam int GROUPS = N_IN / 4;
    localparam int REM    = N_IN % 4;

    function automatic logic [WIDTH-1:0] csa_sum(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] c);
        return a ^ b ^ c;
    endfunction

    // Majority bits carry into the next column; the top carry falls off.
    function automatic logic [WIDTH-1:0] csa_carry(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        return maj << 1;
    endfunction

    for (genvar g = 0; g < GROUPS; g++) begin : g_c42
        logic [WIDTH-1:0] s1;
        logic [WIDTH-1:0] c1;
        assign s1 = csa_sum(in_vec[4*g], in_vec[4*g+1], in_vec[4*g+2]);
        assign c1 = csa_carry(in_vec[4*g], in_vec[4*g+1], in_vec[4*g+2]);
        assign out_vec[2*g]   = csa_sum(s1, c1, in_vec[4*g+3]);
        assign out_vec[2*g+1] = csa_carry(s1, c1, in_vec[4*g+3]);
    end

    if (REM == 3) begin : g_c32
        assign out_vec[2*GROUPS]   = csa_sum(in_vec[4*GROUPS], in_vec[4*GROUPS+1],
                                             in_vec[4*GROUPS+2]);
        assign out_vec[2*GROUPS+1] = csa_carry(in_vec[4*GROUPS], in_vec[4*GROUPS+1],
                                               in_vec[4*GROUPS+2]);
    end else if (REM == 2) begin : g_pass2
        assign out_vec[2*GROUPS]   = in_vec[4*GROUPS];
        assign out_vec[2*GROUPS+1] = in_vec[4*GROUPS+1];
    end else if (REM == 1) begin : g_pass1
        assign out_vec[2*GROUPS] = in_vec[4*GROUPS];
    end

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined N-operand carry-save tree with elastic valid/ready stages, a
// sideband tag and an optional registered carry-propagate adder at the end.
module csa_tree_pipe import csa_tree_pipe_pkg::*; #(
    parameter int N         = 8,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = IN_WIDTH + clog2(N),
    parameter int REG_EVERY = 1,
    parameter int FINAL_ADD = 0,
    parameter int TAG_WIDTH = 4
) (
    input logic           clk_i,
    input logic           rst_i,
    csa_tree_pipe_if.slave bus
);
    localparam int L = csa_levels(N);
    localparam int S = csa_stages(L, REG_EVERY);

    logic [N-1:0][OUT_WIDTH-1:0] ext_ops;
    logic [S-1:0]                valid_q, valid_d, stg_ready, load;
    logic [S-1:0][TAG_WIDTH-1:0] tag_q, tag_d;
    logic [S:0]                  chain_valid;
    logic [S:0][TAG_WIDTH-1:0]   chain_tag;
    logic                        tail_ready;
    logic [OUT_WIDTH-1:0]        tree_sum, tree_carry;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ext_ops[i] = {OUT_WIDTH{bus.signed_i & bus.operands_i[i][IN_WIDTH-1]}};
            ext_ops[i][IN_WIDTH-1:0] = bus.operands_i[i];
        end
    end

    // Entry 0 is the input port, entry s+1 is the output of stage s.
    assign chain_valid = {valid_q, bus.valid_i};
    assign chain_tag   = {tag_q, bus.tag_i};

    always_comb begin
        logic nxt_ready;
        stg_ready = '0;
        nxt_ready = tail_ready;
        for (int s = S - 1; s >= 0; s--) begin
            nxt_ready    = ~valid_q[s] | nxt_ready;
            stg_ready[s] = nxt_ready;
        end
    end

    always_comb begin
        load    = '0;
        valid_d = valid_q;
        tag_d   = tag_q;
        for (int s = 0; s < S; s++) begin
            load[s] = chain_valid[s] & stg_ready[s];
            if (stg_ready[s]) valid_d[s] = chain_valid[s];
            if (chain_valid[s] & stg_ready[s]) tag_d[s] = chain_tag[s];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.ready_o = stg_ready[0];

    if (L == 0) begin : g_flat
        // One or two operands: nothing to compress, just register them.
        logic [N-1:0][OUT_WIDTH-1:0] vec_q, vec_d;
        always_comb vec_d = load[0] ? ext_ops : vec_q;
        always_ff @(posedge clk_i) begin
            if (rst_i) vec_q <= '0;
            else       vec_q <= vec_d;
        end
        assign tree_sum = vec_q[0];
        if (N > 1) begin : g_two
            assign tree_carry = vec_q[N-1];
        end else begin : g_one
            assign tree_carry = '0;
        end
    end else begin : g_tree
        for (genvar k = 0; k < L; k++) begin : g_lvl
            localparam int CIN   = csa_count(N, k);
            localparam int COUT  = csa_count(N, k + 1);
            localparam int STG   = k / REG_EVERY;
            localparam bit CLOSE = ((k % REG_EVERY) == (REG_EVERY - 1)) || (k == L - 1);

            logic [CIN-1:0][OUT_WIDTH-1:0]  in_vec;
            logic [COUT-1:0][OUT_WIDTH-1:0] red_vec, out_vec;

            if (k == 0) begin : g_src
                assign in_vec = ext_ops;
            end else begin : g_src
                assign in_vec = g_lvl[k-1].out_vec;
            end

            csa_tree_pipe_reduce_level #(
                .N_IN  (CIN),
                .WIDTH (OUT_WIDTH)
            ) u_level (
                .in_vec  (in_vec),
                .out_vec (red_vec)
            );

            if (CLOSE) begin : g_reg
                logic [COUT-1:0][OUT_WIDTH-1:0] vec_q, vec_d;
                always_comb vec_d = load[STG] ? red_vec : vec_q;
                always_ff @(posedge clk_i) begin
                    if (rst_i) vec_q <= '0;
                    else       vec_q <= vec_d;
                end
                assign out_vec = vec_q;
            end else begin : g_wire
                assign out_vec = red_vec;
            end
        end
        assign tree_sum   = g_lvl[L-1].out_vec[0];
        assign tree_carry = g_lvl[L-1].out_vec[1];
    end

    if (FINAL_ADD != 0) begin : g_cpa
        logic                 out_valid_q, out_valid_d, cpa_load;
        logic [OUT_WIDTH-1:0] sum_q, sum_d, carry_q, carry_d, result_q, result_d;
        logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

        assign tail_ready = ~out_valid_q | bus.ready_i;

        always_comb begin
            cpa_load    = chain_valid[S] & tail_ready;
            out_valid_d = tail_ready ? chain_valid[S] : out_valid_q;
            sum_d       = cpa_load ? tree_sum : sum_q;
            carry_d     = cpa_load ? tree_carry : carry_q;
            result_d    = cpa_load ? tree_sum + tree_carry : result_q;
            out_tag_d   = cpa_load ? chain_tag[S] : out_tag_q;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                out_valid_q <= 1'b0;
                sum_q       <= '0;
                carry_q     <= '0;
                result_q    <= '0;
                out_tag_q   <= '0;
            end else begin
                out_valid_q <= out_valid_d;
                sum_q       <= sum_d;
                carry_q     <= carry_d;
                result_q    <= result_d;
                out_tag_q   <= out_tag_d;
            end
        end

        assign bus.valid_o  = out_valid_q;
        assign bus.sum_o    = sum_q;
        assign bus.carry_o  = carry_q;
        assign bus.result_o = result_q;
        assign bus.tag_o    = out_tag_q;
    end else begin : g_direct
        assign tail_ready   = bus.ready_i;
        assign bus.valid_o  = chain_valid[S];
        assign bus.sum_o    = tree_sum;
        assign bus.carry_o  = tree_carry;
        assign bus.result_o = '0;
        assign bus.tag_o    = chain_tag[S];
    end

endmodule
